// File: rtl/vector_register_read_stage.sv
// Register Read stage: waits for source registers to be free, reads the register file, builds the execution packet.
// Latency: 3 cycles from accept to output_valid when there is no hazard; at best one packet every 3 cycles.
// Backpressure: input_ready drops while a packet is in flight; output_packet holds until output_ready.

package vector_register_read_pkg;
   localparam int VLEN                       = 64;
   localparam int VRR_PHYS_REGS              = 32;
   localparam int VRR_TAG_LENGTH             = $clog2(VRR_PHYS_REGS);
   localparam int VRR_DATA_LENGTH            = VLEN;
   localparam int FUNCTIONAL_UNIT_TAG_LENGTH = 3;
   localparam int EXECUTION_VECTOR_LENGTH    = 16;

   // Physical register tags for the four operand slots, v0 in the top field.
   typedef struct packed {
      logic [VRR_TAG_LENGTH-1:0] v0_tag;
      logic [VRR_TAG_LENGTH-1:0] vs2_tag;
      logic [VRR_TAG_LENGTH-1:0] vs1_tag;
      logic [VRR_TAG_LENGTH-1:0] vd_tag;
   } operand_tag_packet_t;

   // Packet handed over by Decode.
   typedef struct packed {
      logic [FUNCTIONAL_UNIT_TAG_LENGTH-1:0] functional_unit_tag;
      logic [EXECUTION_VECTOR_LENGTH-1:0]    execution_vector;
      operand_tag_packet_t                   operand_tags;
      logic [VRR_DATA_LENGTH-1:0]            scalar_immediate_operand;
   } register_read_packet_t;

   // Packet handed to the execution stage, operands fully resolved.
   typedef struct packed {
      logic [FUNCTIONAL_UNIT_TAG_LENGTH-1:0] functional_unit_tag;
      logic [EXECUTION_VECTOR_LENGTH-1:0]    execution_vector;
      operand_tag_packet_t                   operand_tags;
      logic [VRR_DATA_LENGTH-1:0]            v0_data;
      logic [VRR_DATA_LENGTH-1:0]            vs2_data;
      logic [VRR_DATA_LENGTH-1:0]            vs1_data;
      logic [VRR_DATA_LENGTH-1:0]            vd_data;
   } execution_packet_t;
endpackage

// The parameters below must agree with the package constants that size the packet structs.
module vector_register_read_stage
   import vector_register_read_pkg::*;
#(
   parameter int NUMBER_PHYSICAL_REGISTERS = VRR_PHYS_REGS,
   parameter int TAG_LENGTH                = $clog2(NUMBER_PHYSICAL_REGISTERS),
   parameter int DATA_LENGTH               = VLEN
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [$bits(register_read_packet_t)-1:0] input_packet,
   input  logic [3:0]                              input_operand_mask,
   input  logic                                    input_write_back_request,
   input  logic                                    input_use_scalar,
   input  logic                                    input_valid,
   output logic                                    input_ready,
   output logic                                    register_file_read_enable,
   output logic [$bits(operand_tag_packet_t)-1:0]  register_file_read_tags,
   input  logic [4*DATA_LENGTH-1:0]                register_file_read_data,
   input  logic                                    write_back_valid,
   input  logic [TAG_LENGTH-1:0]                   write_back_tag,
   input  logic [DATA_LENGTH-1:0]                  write_back_data,
   output logic [$bits(execution_packet_t)-1:0]    output_packet,
   output logic                                    output_valid,
   input  logic                                    output_ready,
   output logic [NUMBER_PHYSICAL_REGISTERS-1:0]    busy_vector
);

   // Operand slot numbering matches the mask bits and the read-data lanes.
   localparam int OPERAND_VD  = 0;
   localparam int OPERAND_VS1 = 1;
   localparam int OPERAND_VS2 = 2;
   localparam int OPERAND_V0  = 3;

   typedef enum logic [1:0] {IDLE, HAZARD_CHECK, CAPTURE, ISSUE} state_t;

   state_t                               state;
   register_read_packet_t                latched_packet;
   logic [3:0]                           latched_mask;
   logic                                 latched_write_back_request;
   logic                                 latched_use_scalar;
   // One write-back port, so every bypassed operand carries the same value;
   // the per-operand flags decide which slots take it.
   logic [3:0]                           bypass_flag;
   logic [DATA_LENGTH-1:0]               bypass_data;
   logic [NUMBER_PHYSICAL_REGISTERS-1:0] busy;
   logic [NUMBER_PHYSICAL_REGISTERS-1:0] busy_next;
   execution_packet_t                    output_packet_register;
   logic                                 output_valid_register;

   logic [TAG_LENGTH-1:0]                operand_tag [4];
   logic [3:0]                           operand_needs_register;
   logic [3:0]                           write_back_hit;
   logic [3:0]                           operand_ready;
   logic                                 all_ready;
   logic                                 accept;
   logic [DATA_LENGTH-1:0]               operand_data [4];
   execution_packet_t                    assembled_packet;

   // Hazard check: an operand is ready when unused, not busy, or being written back this cycle.
   always_comb begin
      operand_tag[OPERAND_VD]  = latched_packet.operand_tags.vd_tag;
      operand_tag[OPERAND_VS1] = latched_packet.operand_tags.vs1_tag;
      operand_tag[OPERAND_VS2] = latched_packet.operand_tags.vs2_tag;
      operand_tag[OPERAND_V0]  = latched_packet.operand_tags.v0_tag;
      // A scalar vs1 never touches the register file, so it can neither stall nor bypass.
      operand_needs_register              = latched_mask;
      operand_needs_register[OPERAND_VS1] = latched_mask[OPERAND_VS1] & ~latched_use_scalar;
      for (int k = 0; k < 4; k++) begin
         write_back_hit[k] = write_back_valid && (write_back_tag == operand_tag[k]);
         operand_ready[k]  = !operand_needs_register[k] || !busy[operand_tag[k]] || write_back_hit[k];
      end
      all_ready = &operand_ready;
   end

   // Handshake and register-file strobe; the read is issued in the cycle the hazard clears.
   always_comb begin
      input_ready               = (state == IDLE) || ((state == ISSUE) && output_ready);
      accept                    = input_ready && input_valid;
      register_file_read_enable = (state == HAZARD_CHECK) && all_ready;
      register_file_read_tags   = latched_packet.operand_tags;
   end

   // Operand selection for the CAPTURE cycle: bypass, then scalar, then register-file data.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         operand_data[k] = '0;
         if (latched_mask[k]) begin
            if (bypass_flag[k]) begin
               operand_data[k] = bypass_data;
            end else if ((k == OPERAND_VS1) && latched_use_scalar) begin
               operand_data[k] = latched_packet.scalar_immediate_operand;
            end else begin
               operand_data[k] = register_file_read_data[k*DATA_LENGTH +: DATA_LENGTH];
            end
         end
      end
      assembled_packet                     = '0;
      assembled_packet.functional_unit_tag = latched_packet.functional_unit_tag;
      assembled_packet.execution_vector    = latched_packet.execution_vector;
      assembled_packet.operand_tags        = latched_packet.operand_tags;
      assembled_packet.v0_data             = operand_data[OPERAND_V0];
      assembled_packet.vs2_data            = operand_data[OPERAND_VS2];
      assembled_packet.vs1_data            = operand_data[OPERAND_VS1];
      assembled_packet.vd_data             = operand_data[OPERAND_VD];
   end

   // Pipeline FSM: latches the incoming packet, records bypasses, registers the output packet.
   always_ff @(posedge clock) begin
      if (reset) begin
         state                      <= IDLE;
         latched_packet             <= '0;
         latched_mask               <= '0;
         latched_write_back_request <= 1'b0;
         latched_use_scalar         <= 1'b0;
         bypass_flag                <= '0;
         bypass_data                <= '0;
         output_packet_register     <= '0;
         output_valid_register      <= 1'b0;
      end else begin
         if (accept) begin
            latched_packet             <= input_packet;
            latched_mask               <= input_operand_mask;
            latched_write_back_request <= input_write_back_request;
            latched_use_scalar         <= input_use_scalar;
         end
         case (state)
            IDLE: begin
               if (input_valid) begin
                  state <= HAZARD_CHECK;
               end
            end
            HAZARD_CHECK: begin
               if (all_ready) begin
                  bypass_flag <= operand_needs_register & write_back_hit;
                  bypass_data <= write_back_data;
                  state       <= CAPTURE;
               end
            end
            CAPTURE: begin
               output_packet_register <= assembled_packet;
               output_valid_register  <= 1'b1;
               state                  <= ISSUE;
            end
            ISSUE: begin
               if (output_ready) begin
                  output_valid_register <= 1'b0;
                  state                 <= input_valid ? HAZARD_CHECK : IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Scoreboard next state: write-back clears first, so an issue to the same tag wins.
   always_comb begin
      busy_next = busy;
      if (write_back_valid) begin
         busy_next[write_back_tag] = 1'b0;
      end
      if ((state == CAPTURE) && latched_write_back_request) begin
         busy_next[latched_packet.operand_tags.vd_tag] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   assign output_packet = output_packet_register;
   assign output_valid  = output_valid_register;
   assign busy_vector   = busy;

endmodule

// File: doc/vector_register_read_stage.md
Name: vector_register_read_stage

Overview:
Register Read stage of the Dragonfang vector pipeline. It sits between Decode and the functional-unit issue/execution stage. It takes a register_read_packet_t from Decode, waits until every source physical register it needs is free, reads operands from the external physical register file, and emits an execution_packet_t. It keeps a busy scoreboard that is set on issue and cleared by write-back, and it forwards write-back data that arrives in the same cycle as the hazard check.

Parameters:
NUMBER_PHYSICAL_REGISTERS, 32, number of physical vector registers and scoreboard entries.
TAG_LENGTH, $clog2(NUMBER_PHYSICAL_REGISTERS), width of a physical register tag.
DATA_LENGTH, VLEN, width of a vector register.

Ports:
clock  input  1  single pipeline clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
input_packet  input  $bits(register_read_packet_t)  packet from Decode.
input_operand_mask  input  4  operand-use bits: [3] v0, [2] vs2, [1] vs1, [0] vd.
input_write_back_request  input  1  packet writes vd; mark vd busy on issue.
input_use_scalar  input  1  vs1 data comes from scalar_immediate_operand instead of the register file.
input_valid  input  1  Decode has a packet.
input_ready  output  1  stage can accept a packet.
register_file_read_enable  output  1  synchronous read strobe; data returns next cycle.
register_file_read_tags  output  $bits(operand_tag_packet_t)  read addresses.
register_file_read_data  input  4*DATA_LENGTH  {v0,vs2,vs1,vd} data, valid the cycle after the enable.
write_back_valid  input  1  write-back broadcast.
write_back_tag  input  TAG_LENGTH  register being written.
write_back_data  input  DATA_LENGTH  written value.
output_packet  output  $bits(execution_packet_t)  packet to execution.
output_valid  output  1  output_packet is valid.
output_ready  input  1  execution accepts.
busy_vector  output  NUMBER_PHYSICAL_REGISTERS  scoreboard, bit i means register i is busy.

Behaviour:
- Reset: state IDLE; input_ready=1; output_valid=0; register_file_read_enable=0; busy_vector=0; output_packet=0; all latched state cleared. Reset aborts a packet in flight and drops it.
- FSM states: IDLE, HAZARD_CHECK, CAPTURE, ISSUE.
- IDLE:
  - input_ready=1.
  - On input_valid, latch the packet, mask and flags, then go to HAZARD_CHECK.
- HAZARD_CHECK:
  - Operand k is ready if its mask bit is 0, or busy[tag_k]=0, or (write_back_valid && write_back_tag==tag_k).
  - vs1 with input_use_scalar=1 is always ready.
  - All ready: set register_file_read_enable=1 and drive the tags this cycle. Record a per-operand bypass flag and data for each write-back match, then go to CAPTURE.
  - Otherwise: stay; read_enable=0.
- CAPTURE:
  - Build output_packet: functional_unit_tag and execution_vector copied; every operand tag copied.
  - Operand data priority: bypass data, then scalar_immediate_operand (vs1 with use_scalar), then register_file_read_data; unused operands are 0.
  - If write_back_request, set busy[vd tag]. Go to ISSUE.
- ISSUE:
  - output_valid=1, and output_packet stays stable until accepted.
  - On output_ready, return to IDLE. In that same cycle input_ready=1 and a new input_valid is accepted straight into HAZARD_CHECK.
- Latency from accept to output_valid is 3 cycles with no hazard. Best throughput is 1 packet per 3 cycles.
- Scoreboard update each cycle: clear busy[write_back_tag] on write_back_valid, then apply the CAPTURE set. If set and clear hit the same tag in the same cycle, set wins.
- A write-back to a non-busy tag is harmless: the bit stays clear.
- An operand whose tag equals a write-back in the CAPTURE cycle is not re-bypassed. That case cannot occur, because such a register was already non-busy at the check.
- Duplicate tags across operands are legal; each operand resolves independently.

Test Plan:
- Reset, then packet vs2=3, vs1=5, mask=0110, no busy regs, regfile returns 0xA/0xB -> output_valid exactly 3 cycles after accept; vs2 data 0xA, vs1 data 0xB, v0/vd data 0.
- Packet with write_back_request, vd=7 -> busy_vector[7]=1 from the CAPTURE edge. Next packet reading vs2=7 stalls in HAZARD_CHECK until write_back_valid with tag 7 arrives.
- Stalled on tag 7; write_back_valid, tag 7, data 0x55 arrives during HAZARD_CHECK -> no extra stall; output vs2 data 0x55 (bypass), not the stale regfile value; busy[7]=0.
- input_use_scalar=1, scalar=0x1234, vs1 tag busy -> no stall; vs1 data 0x1234.
- Hold output_ready=0 for 5 cycles -> output_packet stable and input_ready=0. Raise output_ready with input_valid=1 -> new packet accepted the same cycle.
- Same-cycle set and clear on vd=9 -> busy[9]=1. Reset asserted mid-HAZARD_CHECK -> next cycle IDLE, output_valid=0, busy_vector=0.
